// File: rtl/byte_unstriping.sv
// byte_unstriping: merges two skewed byte lanes back into one stream in strict lane 0 / lane 1 order
module byte_unstriping #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             next_lane,
  output logic             overflow_err
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0][WIDTH-1:0] lane, head;
  logic [1:0] valid, ready, pop, push;
  assign lane = {lane_1, lane_0};
  assign valid = {valid_1, valid_0};
  assign pop = {next_lane & ready[1], ~next_lane & ready[0]};
  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    assign ready[i] = count != '0;
    assign push[i] = valid[i] & ((count != (AW+1)'(DEPTH)) | pop[i]);
    assign head[i] = mem[rd_ptr];
    always_ff @(posedge clk_2f or posedge reset)
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + AW'(1);
        if (pop[i]) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    always_ff @(posedge clk_2f)
      if (push[i]) mem[wr_ptr] <= lane[i];
  end
  always_ff @(posedge clk_2f or posedge reset)
    if (reset) begin
      data_out <= '0;
      valid_out <= 1'b0;
      next_lane <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      valid_out <= |pop;
      if (|pop) begin
        data_out <= head[next_lane];
        next_lane <= ~next_lane;
      end
      if (|(valid & ~push)) overflow_err <= 1'b1;
    end
endmodule

// File: tb/tb_byte_unstriping.sv
// tb_byte_unstriping: table vectors, directed corner sequences and random traffic against a queue model
module tb_byte_unstriping;
  localparam int DEPTH = 4;
  logic clk_2f = 1'b0;
  logic reset = 1'b0;
  logic [7:0] lane_0 = '0, lane_1 = '0;
  logic valid_0 = 1'b0, valid_1 = 1'b0;
  logic [7:0] data_out;
  logic valid_out, next_lane, overflow_err;
  int n_vec = 0, n_bad = 0;
  logic [7:0] q0[$], q1[$];
  logic [7:0] m_d;
  logic m_v, m_nl, m_ovf;
  typedef struct {
    logic v0;
    logic [7:0] l0;
    logic v1;
    logic [7:0] l1;
    logic ev;
    logic [7:0] ed;
    logic enl;
  } vec_t;
  vec_t tbl[8];

  byte_unstriping #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .lane_0(lane_0), .valid_0(valid_0),
    .lane_1(lane_1), .valid_1(valid_1),
    .data_out(data_out), .valid_out(valid_out),
    .next_lane(next_lane), .overflow_err(overflow_err)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data_out"}, data_out, m_d);
    chk({tag, ".valid_out"}, {7'd0, valid_out}, {7'd0, m_v});
    chk({tag, ".next_lane"}, {7'd0, next_lane}, {7'd0, m_nl});
    chk({tag, ".overflow_err"}, {7'd0, overflow_err}, {7'd0, m_ovf});
  endtask

  // Merger behaviour: pop the expected lane from pre-edge contents, then queue arrivals if room remains.
  task automatic model(input logic v0, input logic [7:0] l0, input logic v1, input logic [7:0] l1);
    m_v = 1'b0;
    if (!m_nl && q0.size() > 0) begin
      m_d = q0.pop_front();
      m_v = 1'b1;
      m_nl = 1'b1;
    end else if (m_nl && q1.size() > 0) begin
      m_d = q1.pop_front();
      m_v = 1'b1;
      m_nl = 1'b0;
    end
    if (v0) begin
      if (q0.size() < DEPTH) q0.push_back(l0);
      else m_ovf = 1'b1;
    end
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(l1);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic v0, input logic [7:0] l0, input logic v1, input logic [7:0] l1, input string tag);
    valid_0 = v0;
    lane_0 = l0;
    valid_1 = v1;
    lane_1 = l1;
    @(posedge clk_2f);
    model(v0, l0, v1, l1);
    #1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    m_d = '0;
    m_v = 1'b0;
    m_nl = 1'b0;
    m_ovf = 1'b0;
    chk_all(tag);
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 8'h00, tag);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA0, 1'b1, 8'hA1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA0, 1'b1};
    tbl[2] = '{1'b1, 8'hA2, 1'b1, 8'hA3, 1'b1, 8'hA1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA2, 1'b1};
    tbl[4] = '{1'b1, 8'hA4, 1'b1, 8'hA5, 1'b1, 8'hA3, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA4, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
    do_reset("reset");
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].v0, tbl[k].l0, tbl[k].v1, tbl[k].l1, "inorder");
      chk("tbl.data_out", data_out, tbl[k].ed);
      chk("tbl.valid_out", {7'd0, valid_out}, {7'd0, tbl[k].ev});
      chk("tbl.next_lane", {7'd0, next_lane}, {7'd0, tbl[k].enl});
    end
    do_reset("reset2");
    step(1'b1, 8'h10, 1'b0, 8'h00, "skew");
    step(1'b1, 8'h12, 1'b0, 8'h00, "skew");
    step(1'b1, 8'h14, 1'b0, 8'h00, "skew");
    chk("skew.stall_valid", {7'd0, valid_out}, 8'd0);
    chk("skew.stall_lane", {7'd0, next_lane}, 8'd1);
    step(1'b0, 8'h00, 1'b1, 8'h11, "skew");
    step(1'b0, 8'h00, 1'b1, 8'h13, "skew");
    step(1'b0, 8'h00, 1'b1, 8'h15, "skew");
    idle(5, "skew");
    chk("skew.last", data_out, 8'h15);
    chk("skew.ovf", {7'd0, overflow_err}, 8'd0);
    do_reset("reset3");
    for (int k = 0; k < 6; k++) step(1'b1, 8'h30 + 8'(k), 1'b0, 8'h00, "ovf");
    chk("ovf.set", {7'd0, overflow_err}, 8'd1);
    idle(2, "ovf");
    step(1'b0, 8'h00, 1'b1, 8'h40, "ovf");
    step(1'b0, 8'h00, 1'b0, 8'h00, "ovf");
    chk("ovf.first_l1", data_out, 8'h40);
    step(1'b0, 8'h00, 1'b0, 8'h00, "ovf");
    chk("ovf.resume_l0", data_out, 8'h31);
    chk("ovf.sticky", {7'd0, overflow_err}, 8'd1);
    do_reset("reset4");
    for (int k = 0; k < 5; k++) step(1'b1, 8'h50 + 8'(k), 1'b0, 8'h00, "full");
    step(1'b0, 8'h00, 1'b1, 8'h60, "full");
    step(1'b0, 8'h00, 1'b0, 8'h00, "full");
    step(1'b1, 8'h55, 1'b0, 8'h00, "full");
    chk("full.no_drop", {7'd0, overflow_err}, 8'd0);
    chk("full.popped", data_out, 8'h51);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 8'h61 + 8'(k), "full");
    idle(8, "full");
    chk("full.last", data_out, 8'h55);
    do_reset("reset5");
    for (int k = 0; k < 4; k++) step(1'b1, 8'h70 + 8'(k), 1'b0, 8'h00, "mid");
    chk("mid.lane_before", {7'd0, next_lane}, 8'd1);
    do_reset("mid.reset");
    step(1'b1, 8'h55, 1'b0, 8'h00, "mid");
    step(1'b0, 8'h00, 1'b1, 8'h66, "mid");
    chk("mid.first", data_out, 8'h55);
    step(1'b0, 8'h00, 1'b0, 8'h00, "mid");
    chk("mid.second", data_out, 8'h66);
    idle(4, "mid");
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 249) == 0) do_reset("rnd.reset");
      else step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 4, 8'($urandom), "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
